// File: rtl/dmem_sram_bridge.sv
// MEM-stage to split-transaction SRAM bus bridge: one outstanding access, pipeline
// stall until completion, and a watchdog that raises a sticky bus error on timeout.
module dmem_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_LAST    =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait;
  logic             w_timeout;
  logic             w_unused;

  assign w_wait    = (r_state == S_ADDR) || (r_state == S_DATA);
  // Fires on the last permitted wait cycle, so the stall drops right after it.
  // A handshake arriving in that same cycle still completes normally.
  assign w_timeout = TIMEOUT_EN && w_wait && (r_cnt == TO_LAST);
  assign mem_stall = ((r_state == S_IDLE) && mem_en) || w_wait;
  // Bus is word-addressed; the byte offset is consumed by the MEM stage.
  assign w_unused  = ^mem_addr[1:0];

  // NOTE: assign the default first so every path drives w_state_next and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mem_en) w_state_next = S_ADDR;
      S_ADDR:  if (data_addr_ok || w_timeout) w_state_next = data_addr_ok ? S_DATA : S_DONE;
      S_DATA:  if (data_data_ok || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking so every register samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_wstrb <= 4'b0000;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      mem_rdata  <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (mem_en) begin
            data_req   <= 1'b1;
            data_wr    <= |mem_wen;
            data_wstrb <= mem_wen;
            data_addr  <= {mem_addr[31:2], 2'b00};
            data_wdata <= mem_wdata;
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
          end else if (w_timeout) begin
            data_req <= 1'b0;
            bus_err  <= 1'b1;
            if (!data_wr) mem_rdata <= 32'h0;
          end
        end
        S_DATA: begin
          if (data_data_ok) begin
            if (!data_wr) mem_rdata <= data_rdata;
          end else if (w_timeout) begin
            bus_err <= 1'b1;
            if (!data_wr) mem_rdata <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: table-driven transactions, hand-written corner cases,
// and randomized ops checked against a transaction-level expectation.
module tb_dmem_sram_bridge;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_err;

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    int          first_req_k;
    bit          req_stable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err_done;
    logic        err_during;
    int          done_cyc;
    int          req_cyc;
  } obs_t;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a;
    int          d;
    logic [31:0] exp_addr;
    logic        exp_wr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    int          exp_stall;
    int          exp_req;
  } vec_t;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   req_rises = 0;
  logic req_prev  = 1'b0;

  dmem_sram_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= data_req;
  end

  initial begin
    #200us;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one op from IDLE (called at posedge+1) and records what the bus did.
  // Slave accepts the address after a wait cycles and returns data after d more.
  // noise: 0 none, 1 stray data_ok through ADDR and stray addr_ok afterwards, 2 random strays.
  task automatic do_op(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int a, input int d, input int noise,
                       output obs_t o);
    bit done = 0;
    o = '{default: 0};
    o.first_req_k = -1;
    o.req_stable  = 1'b1;
    mem_en    = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int k = 0; k < 40 && !done; k++) begin
      data_addr_ok = (k == 1 + a);
      data_data_ok = (k == 2 + a + d);
      data_rdata   = (k == 2 + a + d) ? rdata : (32'hBAD0_0000 | 32'(k));
      if (noise == 1) begin
        if (k <= 1 + a) data_data_ok = 1'b1;
        if (k > 1 + a)  data_addr_ok = 1'b1;
      end else if (noise == 2) begin
        if (k <= 1 + a) data_data_ok = 1'($urandom_range(0, 1));
        if (k > 1 + a)  data_addr_ok = 1'($urandom_range(0, 1));
      end
      #1;
      if (data_req) begin
        if (o.req_cnt == 0) begin
          o.addr = data_addr; o.wdata = data_wdata; o.wr = data_wr; o.strb = data_wstrb;
          o.first_req_k = k;
          o.req_cyc = cyc;
        end else if (data_addr !== o.addr || data_wdata !== o.wdata ||
                     data_wr !== o.wr || data_wstrb !== o.strb) begin
          o.req_stable = 1'b0;
        end
        o.req_cnt++;
      end
      if (mem_stall) begin
        o.stall_cnt++;
        if (bus_err) o.err_during = 1'b1;
      end else begin
        o.rdata    = mem_rdata;
        o.err_done = bus_err;
        o.done_cyc = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("op_completes_within_bound", 32'd0, 32'd1);
    mem_en       = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
  endtask

  task automatic check_op(input string tag, input obs_t o, input logic [31:0] e_addr,
                          input logic e_wr, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input int e_stall, input int e_req,
                          input logic e_err);
    check({tag, "_stall_cycles"}, o.stall_cnt, e_stall);
    check({tag, "_req_cycles"}, o.req_cnt, e_req);
    check({tag, "_req_first_cycle"}, o.first_req_k, 32'd1);
    check({tag, "_req_stable"}, 32'(o.req_stable), 32'd1);
    check({tag, "_addr"}, o.addr, e_addr);
    check({tag, "_wr"}, 32'(o.wr), 32'(e_wr));
    check({tag, "_wstrb"}, 32'(o.strb), 32'(e_strb));
    check({tag, "_wdata"}, o.wdata, e_wdata);
    check({tag, "_rdata"}, o.rdata, e_rdata);
    check({tag, "_bus_err"}, 32'(o.err_done), 32'(e_err));
  endtask

  vec_t        tbl [6];
  obs_t        o1;
  obs_t        o2;
  logic [31:0] model_rdata;
  logic [3:0]  r_wen;
  logic [31:0] r_addr, r_wdata, r_rdata;
  int          r_a, r_d, r_gap, rises0;

  initial begin
    //          wen      addr          wdata         rdata         a  d  exp_addr      wr    strb     exp_rdata     stall req
    tbl[0] = '{4'b0000, 32'h0000_1006, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 1'b0, 4'b0000, 32'hDEAD_BEEF, 3, 1};
    tbl[1] = '{4'b0100, 32'h0000_0020, 32'h00AB_0000, 32'h5555_5555, 3, 0, 32'h0000_0020, 1'b1, 4'b0100, 32'hDEAD_BEEF, 6, 4};
    tbl[2] = '{4'b0000, 32'h0000_0ABF, 32'hFFFF_0000, 32'h1234_5678, 1, 2, 32'h0000_0ABC, 1'b0, 4'b0000, 32'h1234_5678, 6, 2};
    tbl[3] = '{4'b1111, 32'h8000_0002, 32'hCAFE_F00D, 32'h0000_0000, 2, 1, 32'h8000_0000, 1'b1, 4'b1111, 32'h1234_5678, 6, 3};
    tbl[4] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_0F0F, 0, 2, 32'hFFFF_FFFC, 1'b0, 4'b0000, 32'hA5A5_0F0F, 5, 1};
    tbl[5] = '{4'b0011, 32'h0000_0041, 32'h0000_BEEF, 32'h7777_7777, 2, 2, 32'h0000_0040, 1'b1, 4'b0011, 32'hA5A5_0F0F, 7, 3};

    rst = 1'b0; mem_en = 1'b0; mem_wen = 4'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_req", 32'(data_req), 32'd0);
    check("reset_data_wr", 32'(data_wr), 32'd0);
    check("reset_data_wstrb", 32'(data_wstrb), 32'd0);
    check("reset_data_addr", data_addr, 32'd0);
    check("reset_data_wdata", data_wdata, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    check("reset_bus_err", 32'(bus_err), 32'd0);
    check("reset_mem_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].a, tbl[i].d, 0, o1);
      check_op($sformatf("tbl%0d", i), o1, tbl[i].exp_addr, tbl[i].exp_wr, tbl[i].exp_strb,
               tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_stall, tbl[i].exp_req, 1'b0);
    end

    // Back-to-back load then store, mem_en held through DONE of the load.
    rises0 = req_rises;
    do_op(4'b0000, 32'h0000_0100, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, o1);
    do_op(4'b1000, 32'h0000_0104, 32'h7F00_0000, 32'h0, 0, 0, 0, o2);
    check_op("b2b_load", o1, 32'h0000_0100, 1'b0, 4'b0000, 32'h0, 32'h0BAD_CAFE, 3, 1, 1'b0);
    check_op("b2b_store", o2, 32'h0000_0104, 1'b1, 4'b1000, 32'h7F00_0000, 32'h0BAD_CAFE, 3, 1, 1'b0);
    check("b2b_second_req_after_done", o2.req_cyc - o1.done_cyc, 32'd2);
    @(negedge clk);
    check("b2b_request_count", req_rises - rises0, 32'd2);
    @(posedge clk);
    #1;

    // Stray handshakes while idle, then coincident data_ok with addr_ok in ADDR.
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("idle_noise%0d_stall", i), 32'(mem_stall), 32'd0);
      check($sformatf("idle_noise%0d_req", i), 32'(data_req), 32'd0);
      @(posedge clk);
      #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    check("idle_noise_rdata_kept", mem_rdata, 32'h0BAD_CAFE);
    do_op(4'b0000, 32'h0000_2008, 32'h0, 32'h0F0F_1234, 1, 1, 1, o1);
    check_op("spurious", o1, 32'h0000_2008, 1'b0, 4'b0000, 32'h0, 32'h0F0F_1234, 5, 2, 1'b0);

    // Randomized ops; expected load data is simply the data of the last read.
    model_rdata = 32'h0F0F_1234;
    for (int n = 0; n < 40; n++) begin
      r_wen   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_a     = int'($urandom_range(0, 2));
      r_d     = int'($urandom_range(0, 2));
      do_op(r_wen, r_addr, r_wdata, r_rdata, r_a, r_d, 2, o1);
      if (r_wen == 4'b0000) model_rdata = r_rdata;
      check_op($sformatf("rnd%0d", n), o1, r_addr & 32'hFFFF_FFFC, |r_wen, r_wen, r_wdata,
               model_rdata, r_a + r_d + 3, r_a + 1, 1'b0);
      r_gap = int'($urandom_range(0, 2));
      repeat (r_gap) begin
        data_data_ok = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      data_data_ok = 1'b0;
    end

    // Watchdog: address accepted, data never returned.
    do_op(4'b0000, 32'h0000_0400, 32'h0, 32'h600D_F00D, 0, 0, 0, o1);
    check("pre_timeout_rdata", o1.rdata, 32'h600D_F00D);
    do_op(4'b0000, 32'h0000_0404, 32'h0, 32'h1111_1111, 1, 99, 0, o1);
    check_op("timeout", o1, 32'h0000_0404, 1'b0, 4'b0000, 32'h0, 32'h0, 7, 2, 1'b1);
    check("timeout_err_not_early", 32'(o1.err_during), 32'd0);
    do_op(4'b0000, 32'h0000_0408, 32'h0, 32'h1357_9BDF, 0, 0, 0, o1);
    check_op("after_timeout", o1, 32'h0000_0408, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF, 3, 1, 1'b1);

    // Asynchronous reset in the middle of a DATA wait.
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_0300; mem_wdata = 32'h0;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(posedge clk); #1;
    check("mid_data_stall", 32'(mem_stall), 32'd1);
    #2;
    rst = 1'b0;
    mem_en = 1'b0;
    #1;
    check("async_rst_data_req", 32'(data_req), 32'd0);
    check("async_rst_mem_stall", 32'(mem_stall), 32'd0);
    check("async_rst_bus_err", 32'(bus_err), 32'd0);
    check("async_rst_mem_rdata", mem_rdata, 32'd0);
    check("async_rst_data_addr", data_addr, 32'd0);
    mem_en = 1'b1;
    #1;
    check("async_rst_idle_stall_with_en", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_op(4'b0000, 32'h0000_0C03, 32'h0, 32'h2468_ACE0, 0, 1, 0, o1);
    check_op("post_reset", o1, 32'h0000_0C00, 1'b0, 4'b0000, 32'h0, 32'h2468_ACE0, 4, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
